// File: rtl/rib_timer_pkg.sv
// rib_timer_pkg: register offsets, CTRL bit layout and reset constants for rib_timer
package rib_timer_pkg;
  localparam logic [3:0] TIMER_CTRL  = 4'h0;
  localparam logic [3:0] TIMER_COUNT = 4'h4;
  localparam logic [3:0] TIMER_CMP   = 4'h8;
  localparam logic [3:0] TIMER_PRESC = 4'hC;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_AUTO = 3;
  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;
  typedef struct packed {
    logic auto_rl;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: tick every presc+1 clocks while en; clr or en=0 restarts the divider
// ports: clk, rst, en, clr, presc[15:0] in; tick one-cycle pulse out (built only with RIB_TIMER_PRESC_EN)
`ifdef RIB_TIMER_PRESC_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick
);
  logic [15:0] div;
  assign tick = en & (div == presc);
  always_ff @(posedge clk)
    div <= (rst | clr | ~en | tick) ? '0 : div + 16'd1;
endmodule
`endif

// File: rtl/rib_timer.sv
// rib_timer: RIB-bus machine timer with compare match and registered level interrupt
// ports: clk, rst; req_i/we_i/addr_i/wdata_i bus request; rdata_o registered read data; int_flag_o interrupt vector
// RIB_TIMER_PRESC_EN adds the 16-bit PRESC register at 0xC and the timer_prescaler divider
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
  parameter int          INT_IDX   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  int_flag_o
);
  ctrl_t       ctrl;
  logic [31:0] count, cmp, rd_mux, presc_rd;
  logic [7:0]  int_next;
  logic [3:0]  off;
  logic        wr, wr_ctrl, tick, match;
  assign off     = addr_i[3:0];
  assign wr      = req_i & we_i;
  assign wr_ctrl = wr && off == TIMER_CTRL;
  assign match   = tick && count == cmp;
`ifdef RIB_TIMER_PRESC_EN
  logic [15:0] presc;
  timer_prescaler u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl.en),
    .clr  (wr && off == TIMER_PRESC),
    .presc(presc),
    .tick (tick)
  );
  always_ff @(posedge clk)
    presc <= rst ? '0 : (wr && off == TIMER_PRESC) ? wdata_i[15:0] : presc;
  assign presc_rd = {16'b0, presc};
`else
  assign tick     = ctrl.en;
  assign presc_rd = '0;
`endif
  always_comb begin
    rd_mux = off == TIMER_CTRL  ? {28'b0, ctrl} :
             off == TIMER_COUNT ? count :
             off == TIMER_CMP   ? cmp :
             off == TIMER_PRESC ? presc_rd : '0;
    int_next = '0;
    int_next[INT_IDX] = ctrl.pend & ctrl.ie;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      count      <= '0;
      cmp        <= TIMER_CMP_RST;
      rdata_o    <= '0;
      int_flag_o <= '0;
    end else begin
      if (wr_ctrl)
        {ctrl.auto_rl, ctrl.ie, ctrl.en} <= {wdata_i[CTRL_AUTO], wdata_i[CTRL_IE], wdata_i[CTRL_EN]};
      // a match in the same cycle beats the write-1-clear
      ctrl.pend <= match | (ctrl.pend & ~(wr_ctrl & wdata_i[CTRL_PEND]));
      count <= (wr && off == TIMER_COUNT) ? wdata_i :
               !tick                      ? count :
               (match & ctrl.auto_rl)     ? '0 : count + 32'd1;
      if (wr && off == TIMER_CMP)
        cmp <= wdata_i;
      if (req_i & ~we_i)
        rdata_o <= rd_mux;
      int_flag_o <= int_next;
    end
  end
endmodule
